// File: rtl/vdp_host_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : vdp_host_pkg                                                |
// | Desc   : Shared encodings for the VDP host bridge.                   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package vdp_host_pkg;

    localparam logic [1:0] OP_REG_WRITE = 2'd0;
    localparam logic [1:0] OP_SET_WADDR = 2'd1;
    localparam logic [1:0] OP_VRAM_DATA = 2'd2;
    localparam logic [1:0] OP_RESERVED  = 2'd3;

    localparam logic [1:0] MODE_REG_SEL  = 2'd0;
    localparam logic [1:0] MODE_REG_DATA = 2'd1;
    localparam logic [1:0] MODE_VRAM     = 2'd2;

    localparam logic [7:0] REG_WADDR_LO = 8'd2;
    localparam logic [7:0] REG_WADDR_HI = 8'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] data;
    } bus_op_t;

endpackage
`default_nettype wire

// File: rtl/vdp_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : vdp_cmd_fifo                                                |
// | Desc   : Synchronous command FIFO with full/empty flags.             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module vdp_cmd_fifo
    import vdp_host_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == c_DEPTH);
    assign empty_o = (count_q == '0);
    // A full FIFO refuses pushes even when a pop frees a slot that clock.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/vdp_host_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : vdp_host_bridge                                             |
// | Desc   : Expands queued host commands into VDP CPU-port bus cycles.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module vdp_host_bridge
    import vdp_host_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_arg,
    output logic        busy,
    output logic        err,
    output logic [1:0]  vdp_mode,
    output logic        vdp_write,
    output logic [7:0]  vdp_data,
    input  logic        vdp_rdy
);

    localparam logic [7:0] c_SETUP_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] c_STROBE_LAST = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] c_HOLD_LAST   = 8'(HOLD_CYCLES - 1);

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [17:0] fifo_dout;

    state_e          state_q, state_d;
    bus_op_t [3:0]   ops_q, ops_d;
    logic [2:0]      n_ops_q, n_ops_d;
    logic [2:0]      step_q, step_d;
    logic [7:0]      cyc_q, cyc_d;
    logic [7:0]      cache_reg_q, cache_reg_d;
    logic            cache_vld_q, cache_vld_d;
    logic [1:0]      mode_q, mode_d;
    logic [7:0]      data_q, data_d;
    logic            err_q, err_d;

    bus_op_t [3:0]   dec_ops;
    logic [2:0]      dec_n;
    logic [7:0]      dec_cache_reg;
    logic            dec_err;
    logic [1:0]      head_op;
    logic [15:0]     head_arg;
    logic [2:0]      step_inc;

    vdp_cmd_fifo #(
        .WIDTH (18),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (cmd_valid),
        .data_i  ({cmd_op, cmd_arg}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_op  = fifo_dout[17:16];
    assign head_arg = fifo_dout[15:0];

    // Decode the FIFO head into its bus-op list, skipping a select already cached.
    always_comb begin
        dec_ops       = '0;
        dec_n         = 3'd0;
        dec_cache_reg = cache_reg_q;
        dec_err       = 1'b0;
        case (head_op)
            OP_REG_WRITE: begin
                dec_cache_reg = head_arg[15:8];
                if (cache_vld_q && (cache_reg_q == head_arg[15:8])) begin
                    dec_ops[0] = {MODE_REG_DATA, head_arg[7:0]};
                    dec_n      = 3'd1;
                end else begin
                    dec_ops[0] = {MODE_REG_SEL, head_arg[15:8]};
                    dec_ops[1] = {MODE_REG_DATA, head_arg[7:0]};
                    dec_n      = 3'd2;
                end
            end
            OP_SET_WADDR: begin
                dec_cache_reg = REG_WADDR_HI;
                if (cache_vld_q && (cache_reg_q == REG_WADDR_LO)) begin
                    dec_ops[0] = {MODE_REG_DATA, head_arg[7:0]};
                    dec_ops[1] = {MODE_REG_SEL, REG_WADDR_HI};
                    dec_ops[2] = {MODE_REG_DATA, head_arg[15:8]};
                    dec_n      = 3'd3;
                end else begin
                    dec_ops[0] = {MODE_REG_SEL, REG_WADDR_LO};
                    dec_ops[1] = {MODE_REG_DATA, head_arg[7:0]};
                    dec_ops[2] = {MODE_REG_SEL, REG_WADDR_HI};
                    dec_ops[3] = {MODE_REG_DATA, head_arg[15:8]};
                    dec_n      = 3'd4;
                end
            end
            OP_VRAM_DATA: begin
                dec_ops[0] = {MODE_VRAM, head_arg[7:0]};
                dec_n      = 3'd1;
            end
            default: dec_err = 1'b1;
        endcase
    end

    assign step_inc = step_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        ops_d       = ops_q;
        n_ops_d     = n_ops_q;
        step_d      = step_q;
        cyc_d       = cyc_q;
        cache_reg_d = cache_reg_q;
        cache_vld_d = cache_vld_q;
        mode_d      = mode_q;
        data_d      = data_q;
        err_d       = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    ops_d       = dec_ops;
                    n_ops_d     = dec_n;
                    step_d      = 3'd0;
                    err_d       = dec_err;
                    cache_reg_d = dec_cache_reg;
                    cache_vld_d = cache_vld_q || !dec_err;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (step_q < n_ops_q) begin
                    mode_d  = ops_q[step_q[1:0]].mode;
                    data_d  = ops_q[step_q[1:0]].data;
                    cyc_d   = 8'd0;
                    state_d = ST_SETUP;
                end else if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    ops_d       = dec_ops;
                    n_ops_d     = dec_n;
                    step_d      = 3'd0;
                    err_d       = dec_err;
                    cache_reg_d = dec_cache_reg;
                    cache_vld_d = cache_vld_q || !dec_err;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cyc_q == c_SETUP_LAST) begin
                    cyc_d   = 8'd0;
                    state_d = ST_STROBE;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            ST_STROBE: begin
                // Count saturates at the minimum width; rdy alone then releases the strobe.
                if (cyc_q >= c_STROBE_LAST) begin
                    if (vdp_rdy) begin
                        cyc_d   = 8'd0;
                        state_d = ST_HOLD;
                    end
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (cyc_q == c_HOLD_LAST) begin
                    cyc_d  = 8'd0;
                    step_d = step_inc;
                    if (step_inc < n_ops_q) begin
                        mode_d  = ops_q[step_inc[1:0]].mode;
                        data_d  = ops_q[step_inc[1:0]].data;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ops_q       <= '0;
            n_ops_q     <= 3'd0;
            step_q      <= 3'd0;
            cyc_q       <= 8'd0;
            cache_reg_q <= 8'd0;
            cache_vld_q <= 1'b0;
            mode_q      <= 2'd0;
            data_q      <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ops_q       <= ops_d;
            n_ops_q     <= n_ops_d;
            step_q      <= step_d;
            cyc_q       <= cyc_d;
            cache_reg_q <= cache_reg_d;
            cache_vld_q <= cache_vld_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign err       = err_q;
    assign vdp_mode  = mode_q;
    assign vdp_data  = data_q;
    assign vdp_write = (state_q == ST_STROBE);

endmodule
`default_nettype wire

// File: tb/tb_vdp_host_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_vdp_host_bridge                                          |
// | Desc   : Self-checking bench for vdp_host_bridge with a command model.|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_vdp_host_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_arg = 16'd0;
    logic        vdp_rdy = 1'b1;
    logic        cmd_ready, busy, err, vdp_write;
    logic [1:0]  vdp_mode;
    logic [7:0]  vdp_data;

    always #5 clk = ~clk;

    vdp_host_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .busy      (busy),
        .err       (err),
        .vdp_mode  (vdp_mode),
        .vdp_write (vdp_write),
        .vdp_data  (vdp_data),
        .vdp_rdy   (vdp_rdy)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed bus ops, captured from the write strobe as the VDP would see them.
    logic [9:0] obs_op[$];
    int         obs_len[$];
    int         obs_rise[$];
    bit         obs_stable[$];
    logic [9:0] cur_op = '0;
    int         rise_c = 0;
    bit         stable = 1'b1;
    logic       prev_w = 1'b0;
    logic       prev_err = 1'b0;
    int         err_cycles = 0;
    int         err_pulses = 0;

    always @(negedge clk) begin
        if (vdp_write && !prev_w) begin
            rise_c = cyc;
            cur_op = {vdp_mode, vdp_data};
            stable = 1'b1;
        end else if (vdp_write && ({vdp_mode, vdp_data} !== cur_op)) begin
            stable = 1'b0;
        end else if (!vdp_write && prev_w) begin
            if ({vdp_mode, vdp_data} !== cur_op) stable = 1'b0;
            obs_op.push_back(cur_op);
            obs_len.push_back(cyc - rise_c);
            obs_rise.push_back(rise_c);
            obs_stable.push_back(stable);
        end
        if (err) err_cycles++;
        if (err && !prev_err) err_pulses++;
        prev_w   = vdp_write;
        prev_err = err;
    end

    // VDP rdy behaviour: 0 ready, 1 held low, 2 random, 3 stall 5 clocks on 2nd strobe.
    int   rdy_mode = 0;
    int   rises = 0;
    int   stall_left = 0;
    logic rdy_prev_w = 1'b0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: vdp_rdy = 1'b1;
            1: vdp_rdy = 1'b0;
            2: vdp_rdy = ($urandom_range(0, 2) != 0);
            default: begin
                if (vdp_write && !rdy_prev_w) begin
                    rises++;
                    if (rises == 2) stall_left = 5;
                end
                if (stall_left > 0) begin
                    vdp_rdy = 1'b0;
                    stall_left--;
                end else begin
                    vdp_rdy = 1'b1;
                end
            end
        endcase
        rdy_prev_w = vdp_write;
    end

    // Reference model: expected bus-op sequence from the command rules.
    logic [9:0] exp_q[$];
    int         exp_err = 0;
    bit         m_vld = 1'b0;
    logic [7:0] m_reg = 8'd0;

    task automatic model_cmd(input logic [1:0] op, input logic [15:0] arg);
        case (op)
            2'd0: begin
                if (!(m_vld && m_reg == arg[15:8])) exp_q.push_back({2'd0, arg[15:8]});
                exp_q.push_back({2'd1, arg[7:0]});
                m_vld = 1'b1;
                m_reg = arg[15:8];
            end
            2'd1: begin
                if (!(m_vld && m_reg == 8'd2)) exp_q.push_back({2'd0, 8'd2});
                exp_q.push_back({2'd1, arg[7:0]});
                exp_q.push_back({2'd0, 8'd3});
                exp_q.push_back({2'd1, arg[15:8]});
                m_vld = 1'b1;
                m_reg = 8'd3;
            end
            2'd2: exp_q.push_back({2'd2, arg[7:0]});
            default: exp_err++;
        endcase
    endtask

    task automatic clear_obs();
        obs_op.delete();
        obs_len.delete();
        obs_rise.delete();
        obs_stable.delete();
        exp_q.delete();
        err_cycles = 0;
        err_pulses = 0;
        exp_err    = 0;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic push(input logic [1:0] op, input logic [15:0] arg);
        int t = 0;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL push_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, t);
        end else begin
            @(posedge clk); #1;
            acc_cyc = cyc;
            model_cmd(op, arg);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        if (busy) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, t);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({cmd_ready, busy, err, vdp_write, vdp_mode, vdp_data} !== {4'b1000, 2'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%0b busy=%0b err=%0b wr=%0b mode=%0d data=%02h, required 1 0 0 0 0 00",
                     cmd_ready, busy, err, vdp_write, vdp_mode, vdp_data);
        end
        m_vld = 1'b0;
        clear_obs();
    endtask

    task automatic test_reg_write();
        rdy_mode = 0;
        clear_obs();
        push(2'd0, 16'h0450);
        wait_idle(200);
        n_cmp++;
        if (obs_op.size() != exp_q.size() || obs_op.size() != 2) begin
            n_fail++;
            $display("FAIL reg_write_count: got %0d ops, required %0d", obs_op.size(), exp_q.size());
        end
        for (int i = 0; i < obs_op.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_op[i] !== exp_q[i] || !obs_stable[i] || obs_len[i] != 2) begin
                n_fail++;
                $display("FAIL reg_write_op%0d: got %03h len=%0d stable=%0b, required %03h len=2 stable=1",
                         i, obs_op[i], obs_len[i], obs_stable[i], exp_q[i]);
            end
        end
        if (obs_rise.size() == 2) begin
            n_cmp++;
            if (obs_rise[0] - acc_cyc != 3 || obs_rise[1] - obs_rise[0] != 4) begin
                n_fail++;
                $display("FAIL reg_write_timing: got latency=%0d spacing=%0d, required 3 and 4",
                         obs_rise[0] - acc_cyc, obs_rise[1] - obs_rise[0]);
            end
        end
        clear_obs();
        push(2'd0, 16'h0428);
        wait_idle(200);
        n_cmp++;
        if (obs_op.size() != 1 || exp_q.size() != 1 || obs_op[0] !== exp_q[0] || obs_len[0] != 2) begin
            n_fail++;
            $display("FAIL reg_write_cached: got %0d ops first=%03h, required 1 op %03h", obs_op.size(), obs_op[0], 10'h128);
        end
    endtask

    task automatic test_set_addr();
        clear_obs();
        push(2'd1, 16'h1234);
        push(2'd1, 16'h1234);
        wait_idle(300);
        n_cmp++;
        if (obs_op.size() != exp_q.size() || obs_op.size() != 8) begin
            n_fail++;
            $display("FAIL set_addr_count: got %0d ops, required %0d", obs_op.size(), exp_q.size());
        end
        for (int i = 0; i < obs_op.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_op[i] !== exp_q[i] || !obs_stable[i]) begin
                n_fail++;
                $display("FAIL set_addr_op%0d: got %03h stable=%0b, required %03h", i, obs_op[i], obs_stable[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_vram_stall();
        int req_len[3] = '{2, 6, 2};
        clear_obs();
        rises = 0;
        stall_left = 0;
        rdy_mode = 3;
        for (int i = 0; i < 3; i++) push(2'd2, {8'd0, 8'($urandom)});
        wait_idle(300);
        rdy_mode = 0;
        n_cmp++;
        if (obs_op.size() != 3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL vram_count: got %0d ops, required 3", obs_op.size());
        end
        for (int i = 0; i < obs_op.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_op[i] !== exp_q[i] || obs_len[i] != req_len[i] || !obs_stable[i]) begin
                n_fail++;
                $display("FAIL vram_op%0d: got %03h len=%0d, required %03h len=%0d", i, obs_op[i], obs_len[i], exp_q[i], req_len[i]);
            end
        end
    endtask

    task automatic test_reserved();
        clear_obs();
        push(2'd3, 16'($urandom));
        wait_idle(100);
        n_cmp++;
        if (err_pulses != 1 || err_cycles != exp_err || obs_op.size() != 0) begin
            n_fail++;
            $display("FAIL reserved: got pulses=%0d cycles=%0d ops=%0d, required 1 %0d 0", err_pulses, err_cycles, obs_op.size(), exp_err);
        end
    endtask

    task automatic test_fifo_full();
        int acc = 0;
        int t = 0;
        clear_obs();
        rdy_mode = 1;
        push(2'd2, 16'h00A0);
        while (!vdp_write && t < 50) begin @(posedge clk); #1; t++; end
        n_cmp++;
        if (!vdp_write) begin
            n_fail++;
            $display("FAIL full_first_strobe: vdp_write=%0b, required 1", vdp_write);
        end
        for (int i = 0; i < 17; i++) begin
            cmd_op    = 2'd2;
            cmd_arg   = {8'd0, 8'(8'hB0 + i)};
            cmd_valid = 1'b1;
            if (cmd_ready) acc++;
            if (i < 16) model_cmd(2'd2, {8'd0, 8'(8'hB0 + i)});
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (acc != 16 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_accept: got accepted=%0d ready=%0b busy=%0b, required 16 0 1", acc, cmd_ready, busy);
        end
        rdy_mode = 0;
        wait_idle(1000);
        n_cmp++;
        if (obs_op.size() != 17 || exp_q.size() != 17) begin
            n_fail++;
            $display("FAIL full_count: got %0d ops, required 17", obs_op.size());
        end
        for (int i = 0; i < obs_op.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_op[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL full_op%0d: got %03h, required %03h", i, obs_op[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        rdy_mode = 0;
        clear_obs();
        push(2'd0, 16'h0511);
        while (!vdp_write && t < 50) begin @(posedge clk); #1; t++; end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (vdp_write !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || t >= 50) begin
            n_fail++;
            $display("FAIL reset_mid: got wr=%0b busy=%0b ready=%0b wait=%0d, required 0 0 1 <50", vdp_write, busy, cmd_ready, t);
        end
        reset = 1'b0;
        @(negedge clk); #1;
        m_vld = 1'b0;
        clear_obs();
        @(posedge clk); #1;
        push(2'd0, 16'h0522);
        wait_idle(200);
        n_cmp++;
        if (obs_op.size() != 2 || exp_q.size() != 2 || obs_op[0] !== exp_q[0] || obs_op[1] !== exp_q[1]) begin
            n_fail++;
            $display("FAIL reset_reselect: got %0d ops first=%03h, required 2 ops first=%03h", obs_op.size(), obs_op[0], exp_q[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] regs [4] = '{8'h02, 8'h03, 8'h04, 8'h07};
        int r;
        clear_obs();
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)      push(2'd0, {regs[$urandom_range(0, 3)], 8'($urandom)});
            else if (r <= 4) push(2'd1, 16'($urandom));
            else if (r <= 8) push(2'd2, 16'($urandom));
            else             push(2'd3, 16'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle(3000);
        rdy_mode = 0;
        n_cmp++;
        if (obs_op.size() != exp_q.size() || err_cycles != exp_err) begin
            n_fail++;
            $display("FAIL random_count: got %0d ops err=%0d, required %0d ops err=%0d", obs_op.size(), err_cycles, exp_q.size(), exp_err);
        end
        for (int i = 0; i < obs_op.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_op[i] !== exp_q[i] || !obs_stable[i] || obs_len[i] < 2) begin
                n_fail++;
                $display("FAIL random_op%0d: got %03h len=%0d stable=%0b, required %03h len>=2", i, obs_op[i], obs_len[i], obs_stable[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reg_write();
        test_set_addr();
        test_vram_stall();
        test_reserved();
        test_fifo_full();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
